// File: rtl/fetch_pc.sv
// fetch_pc: fetch-stage program counter with optional direct-mapped BTB and
// 2-bit saturating direction counters.
//
// Build option: define FETCH_PC_BP_EN to include the BTB. Without it there is
// no predictor storage; pred_taken is tied low, pred_target = pcF + 4, and
// every taken branch resolves as a mispredict.
//
// Ports:
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   stall           in   1   hold pcF (redirects still win)
//   res_valid       in   1   branch/jump resolved this cycle (E stage)
//   res_pc          in   32  address of the resolved instruction
//   res_taken       in   1   actual direction
//   res_target      in   32  actual target
//   res_pred_taken  in   1   prediction that travelled with the instruction
//   res_pred_target in   32  predicted target that travelled with it
//   trap            in   1   exception redirect to TRAP_VEC
//   eret            in   1   exception return to epc
//   epc             in   32  return address for eret
//   pcF             out  32  current fetch address (registered)
//   pred_taken      out  1   prediction for pcF (combinational)
//   pred_target     out  32  predicted target for pcF (combinational)
//   flush           out  1   combinational; younger instructions are invalid
module fetch_pc #(
  parameter int unsigned BTB_DEPTH = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  input  logic        trap,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pcF,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush
);

  logic [31:0] seq_pc;
  logic [31:0] pc_next;
  logic        mispredict;

  assign seq_pc = pcF + 32'd4;

  // Wrong direction, or taken to a different address than predicted.
  assign mispredict = res_valid &
                      ((res_taken != res_pred_taken) |
                       (res_taken & (res_target != res_pred_target)));

  assign flush = eret | trap | mispredict;

`ifdef FETCH_PC_BP_EN
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [31:0]          target_q [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             wr_hit;
  logic             alloc;
  logic [1:0]       ctr_upd;

  // pc[1:0] takes no part in index or tag.
  assign rd_idx = pcF[IDX_W+1:2];
  assign rd_tag = pcF[31:IDX_W+2];
  assign wr_idx = res_pc[IDX_W+1:2];
  assign wr_tag = res_pc[31:IDX_W+2];

  // Reads see the array before this edge's update (read-before-write).
  assign rd_hit      = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit & ctr_q[rd_idx][1];
  assign pred_target = rd_hit ? target_q[rd_idx] : seq_pc;

  assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);
  assign alloc  = res_valid & ~wr_hit & res_taken;

  // Saturating counter step for a hit.
  always_comb begin
    ctr_upd = ctr_q[wr_idx];
    if (res_taken) begin
      if (ctr_q[wr_idx] != 2'b11) ctr_upd = ctr_q[wr_idx] + 2'd1;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) ctr_upd = ctr_q[wr_idx] - 2'd1;
    end
  end

  // Valid bits are the only BTB state that needs reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Entry payload: counter/target update on hit, allocation on taken miss.
  always_ff @(posedge clk) begin
    if (res_valid) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_upd;
        if (res_taken) target_q[wr_idx] <= res_target;
      end else if (res_taken) begin
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= res_target;
        ctr_q[wr_idx]    <= 2'b10;
      end
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = seq_pc;
`endif

  // Next fetch address; redirects take precedence over stall.
  always_comb begin
    pc_next = seq_pc;
    if (eret) begin
      pc_next = epc;
    end else if (trap) begin
      pc_next = TRAP_VEC;
    end else if (mispredict) begin
      pc_next = res_taken ? res_target : (res_pc + 32'd4);
    end else if (stall) begin
      pc_next = pcF;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF <= RESET_PC;
    end else begin
      pcF <= pc_next;
    end
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter BTB_DEPTH, default 16, number of BTB entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, fetch address after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_4180, exception handler address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold pcF.
REQ-007 SHALL have port res_valid  input  1  a branch or jump is resolved this cycle (E stage).
REQ-008 SHALL have port res_pc  input  32  address of the resolved instruction.
REQ-009 SHALL have port res_taken  input  1  actual direction.
REQ-010 SHALL have port res_target  input  32  actual target.
REQ-011 SHALL have port res_pred_taken  input  1  prediction carried down the pipe with it.
REQ-012 SHALL have port res_pred_target  input  32  predicted target carried down the pipe with it.
REQ-013 SHALL have port trap  input  1  exception redirect.
REQ-014 SHALL have port eret  input  1  exception return.
REQ-015 SHALL have port epc  input  32  return address for eret.
REQ-016 SHALL have port pcF  output  32  current fetch address (registered).
REQ-017 SHALL have port pred_taken  output  1  prediction for pcF.
REQ-018 SHALL have port pred_target  output  32  predicted target for pcF.
REQ-019 SHALL have port flush  output  1  combinational; younger instructions are invalid.

Function
REQ-020 SHALL use no branch delay slot; the sequential address is pcF+4, modulo 2^32.
REQ-021 SHALL define mispredict = res_valid & (res_taken != res_pred_taken | (res_taken & res_target != res_pred_target)).
REQ-022 SHALL assert flush in the same cycle when eret | trap | mispredict is true.
REQ-023 SHALL load pcF on each edge by this priority: eret->epc; trap->TRAP_VEC; mispredict->(res_taken ? res_target : res_pc+4); stall->hold; pred_taken->pred_target; else pcF+4.
REQ-024 SHALL let redirects (REQ-023, first three) override stall.
REQ-025 SHALL implement the BTB as BTB_DEPTH direct-mapped entries {valid, tag, target[31:0], ctr[1:0]}; index = pc[log2(BTB_DEPTH)+1:2]; tag = remaining upper bits.
REQ-026 SHALL compute pred_taken combinationally as entry hit(pcF) & ctr[1]; pred_target = entry target on hit, else pcF+4.
REQ-027 SHALL, on res_valid and a hit at res_pc, saturate ctr up if taken (max 2'b11) or down if not taken (min 2'b00), and write target if taken.
REQ-028 SHALL, on res_valid, a miss, and res_taken, allocate the entry: valid=1, tag, target, ctr=2'b10; a not-taken miss SHALL leave the BTB unchanged.
REQ-029 SHALL make the prediction read in the cycle of an update to the same index return the pre-update contents.
REQ-030 SHALL ignore pc[1:0] for indexing and tagging.

Reset
REQ-031 SHALL on reset assertion immediately set pcF=RESET_PC and clear all BTB valid bits, so pred_taken=0, pred_target=RESET_PC+4, flush follows its inputs.
REQ-032 SHALL, on reset during a pending redirect, discard the redirect and take RESET_PC.

Configuration
REQ-033 SHALL, with macro FETCH_PC_BP_EN defined, include the BTB as specified.
REQ-034 SHALL, with FETCH_PC_BP_EN undefined, contain no BTB storage and tie pred_taken=0 and pred_target=pcF+4, so every taken branch mispredicts and redirects via REQ-023.

Verification
REQ-035 SHALL cover: reset released, no events, 3 edges -> pcF = 3000, 3004, 3008, 300C.
REQ-036 SHALL cover: res_valid, res_pc=3010, taken, target=3100, pred 0 -> flush=1, next pcF=3100; at next fetch of 3010, pred_taken=1, pred_target=3100.
REQ-037 SHALL cover: entry at ctr=2'b10, resolved not-taken with pred 1 -> flush=1, pcF=res_pc+4, ctr=2'b01, next fetch of that pc pred_taken=0.
REQ-038 SHALL cover: stall=1 with trap=1 and mispredict in the same cycle -> pcF=4180; with eret=1 and epc=3204 also asserted -> pcF=3204.
REQ-039 SHALL cover: aliasing with BTB_DEPTH=16, entries 3010 and 3050 -> 3050 taken allocation evicts 3010; fetch of 3010 -> pred_taken=0.
REQ-040 SHALL cover: pcF=FFFFFFFC, no events -> wraps to 00000000; reset pulsed mid-stall -> pcF=3000 asynchronously.
